// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: access-type codes,
// load/store direction encodings and the responder state type.
package dmem_responder_pkg;

    localparam int DWIDTH       = 32;
    localparam int BYTE         = 8;
    localparam int HALF         = 16;
    localparam int MEM_TYPE_LEN = 3;

    typedef logic [MEM_TYPE_LEN-1:0] mem_type_t;

    localparam mem_type_t MT_X  = 3'd0;
    localparam mem_type_t MT_B  = 3'd1;
    localparam mem_type_t MT_H  = 3'd2;
    localparam mem_type_t MT_W  = 3'd3;
    localparam mem_type_t MT_BU = 3'd5;
    localparam mem_type_t MT_HU = 3'd6;

    // WEN polarity as seen on the bus: low means store
    localparam logic M_W = 1'b0;
    localparam logic M_R = 1'b1;
    localparam logic M_X = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Unused codes (MT_X, 4, 7) are treated as no-ops by the responder
    function automatic logic mt_is_access(input mem_type_t t);
        return (t == MT_B) || (t == MT_H) || (t == MT_W) ||
               (t == MT_BU) || (t == MT_HU);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the core (master) and the data memory (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic              CSN;
    logic              WEN;
    logic [DWIDTH-1:0] ADDR;
    mem_type_t         BE;
    logic [DWIDTH-1:0] DI;
    logic [DWIDTH-1:0] DOUT;
    logic              READY;
    logic              MISALIGN_ERR;

    modport master (
        output CSN, WEN, ADDR, BE, DI,
        input  DOUT, READY, MISALIGN_ERR
    );

    modport slave (
        input  CSN, WEN, ADDR, BE, DI,
        output DOUT, READY, MISALIGN_ERR
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: builds the write mask and lane-replicated store data,
// right-aligns load data and detects misaligned halfword/word accesses.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  mem_type_t         be_i,
    input  logic [DWIDTH-1:0] di_i,
    input  logic [DWIDTH-1:0] raw_word_i,
    output logic [3:0]        wmask_o,
    output logic [DWIDTH-1:0] wdata_o,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              misalign_o
);

    logic [BYTE-1:0] rd_byte;
    logic [HALF-1:0] rd_half;

    assign rd_byte = raw_word_i[{addr_lo_i, 3'b000} +: BYTE];
    assign rd_half = raw_word_i[{addr_lo_i[1], 4'b0000} +: HALF];

    // Store data is replicated across lanes so the mask alone picks the target
    always_comb begin
        wmask_o    = 4'b0000;
        wdata_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        case (be_i)
            MT_B, MT_BU: begin
                wmask_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{di_i[BYTE-1:0]}};
                rdata_o = {{(DWIDTH-BYTE){1'b0}}, rd_byte};
            end
            MT_H, MT_HU: begin
                misalign_o = addr_lo_i[0];
                wmask_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{di_i[HALF-1:0]}};
                rdata_o    = {{(DWIDTH-HALF){1'b0}}, rd_half};
            end
            MT_W: begin
                misalign_o = |addr_lo_i;
                wmask_o    = 4'b1111;
                wdata_o    = di_i;
                rdata_o    = raw_word_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised storage with byte/half/word access,
// single-edge stores and loads stalled by a fixed number of wait states.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    dmem_responder_if.slave  bus
);

    localparam int           DEPTH    = 1 << ADDR_WIDTH;
    localparam int           AW2      = ADDR_WIDTH + 2;
    localparam logic [1:0]   CNT_INIT = 2'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              err_q, err_d;
    logic [AW2-1:0]    addr_q, addr_d;
    mem_type_t         be_q, be_d;

    logic [AW2-1:0]    acc_addr;
    mem_type_t         acc_be;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [DWIDTH-1:0] raw_word;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rdata;
    logic [3:0]        wmask;
    logic              misalign;
    logic              accept;
    logic              wr_en;
    logic              unused_addr_bits;

    // High address bits alias onto the array
    assign unused_addr_bits = ^bus.ADDR[DWIDTH-1:AW2];

    // While stalled the latched request drives the array and aligner
    assign acc_addr = (state_q == ST_WAIT) ? addr_q : bus.ADDR[AW2-1:0];
    assign acc_be   = (state_q == ST_WAIT) ? be_q   : bus.BE;
    assign word_idx = acc_addr[AW2-1:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [BYTE-1:0] lane_mem [DEPTH];

            always_ff @(posedge CLK) begin
                if (wr_en && wmask[gi]) begin
                    lane_mem[word_idx] <= wdata[gi*BYTE +: BYTE];
                end
            end

            assign raw_word[gi*BYTE +: BYTE] = lane_mem[word_idx];
        end
    endgenerate

    dmem_lane_align u_align (
        .addr_lo_i  (acc_addr[1:0]),
        .be_i       (acc_be),
        .di_i       (bus.DI),
        .raw_word_i (raw_word),
        .wmask_o    (wmask),
        .wdata_o    (wdata),
        .rdata_o    (rdata),
        .misalign_o (misalign)
    );

    assign accept = !bus.CSN && (state_q == ST_IDLE) && mt_is_access(bus.BE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        err_d   = 1'b0;
        addr_d  = addr_q;
        be_d    = be_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        err_d = 1'b1;
                    end else if (bus.WEN == M_W) begin
                        wr_en = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        dout_d = rdata;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                        addr_d  = bus.ADDR[AW2-1:0];
                        be_d    = bus.BE;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    dout_d  = rdata;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= MT_X;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
        end
    end

    assign bus.DOUT         = dout_q;
    assign bus.READY        = (state_q == ST_IDLE);
    assign bus.MISALIGN_ERR = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 2 read
// wait states share one stimulus bus; CSN is steered to the selected one.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn0, rstn1, rstn2;
    int          sel;
    logic        csn, wen;
    logic [31:0] addr, di;
    mem_type_t   be;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.CSN = (sel == 0) ? csn : 1'b1;
    assign bus1.CSN = (sel == 1) ? csn : 1'b1;
    assign bus2.CSN = (sel == 2) ? csn : 1'b1;
    assign bus0.WEN = wen;  assign bus1.WEN = wen;  assign bus2.WEN = wen;
    assign bus0.ADDR = addr; assign bus1.ADDR = addr; assign bus2.ADDR = addr;
    assign bus0.BE = be;    assign bus1.BE = be;    assign bus2.BE = be;
    assign bus0.DI = di;    assign bus1.DI = di;    assign bus2.DI = di;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (.CLK(clk), .RSTN(rstn0), .bus(bus0));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (.CLK(clk), .RSTN(rstn1), .bus(bus1));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut2 (.CLK(clk), .RSTN(rstn2), .bus(bus2));

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          sel;
        logic        wen;
        mem_type_t   be;
        logic [31:0] addr;
        logic [31:0] di;
        logic [31:0] exp_dout;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] get_dout(input int s);
        case (s)
            0:       return bus0.DOUT;
            1:       return bus1.DOUT;
            default: return bus2.DOUT;
        endcase
    endfunction

    function automatic logic get_ready(input int s);
        case (s)
            0:       return bus0.READY;
            1:       return bus1.READY;
            default: return bus2.READY;
        endcase
    endfunction

    function automatic logic get_err(input int s);
        case (s)
            0:       return bus0.MISALIGN_ERR;
            1:       return bus1.MISALIGN_ERR;
            default: return bus2.MISALIGN_ERR;
        endcase
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input int s, input logic w, input mem_type_t t, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ed, input int es, input logic ee);
        vec_t v;
        v.sel = s; v.wen = w; v.be = t; v.addr = a; v.di = d;
        v.exp_dout = ed; v.exp_stall = es; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Issues one request at posedge+1, returns at posedge+1 once READY is back
    task automatic do_req(input int s, input logic w, input mem_type_t t, input logic [31:0] a,
                          input logic [31:0] d, output int stall, output logic err_seen);
        sel = s; wen = w; be = t; addr = a; di = d; csn = 1'b0;
        @(posedge clk); #1;
        csn = 1'b0;
        csn = 1'b1;
        err_seen = get_err(s);
        stall = 0;
        while (get_ready(s) !== 1'b1 && stall < 8) begin
            @(posedge clk); #1;
            stall++;
        end
        $display("req dut%0d %s be=%0d addr=0x%08h di=0x%08h -> dout=0x%08h stall=%0d err=%0b",
                 s, w ? "RD" : "WR", t, a, d, get_dout(s), stall, err_seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   st;
        logic er;

        sel = 1; csn = 1'b1; wen = 1'b1; addr = '0; di = '0; be = MT_X;
        rstn0 = 1'b0; rstn1 = 1'b0; rstn2 = 1'b0;

        //        sel wen   be     addr          di            exp_dout      stall err
        add(1, 1'b0, MT_W,  32'h10,   32'hDEADBEEF, 32'h00000000, 0, 1'b0);
        add(1, 1'b1, MT_W,  32'h10,   32'h0,        32'hDEADBEEF, 1, 1'b0);
        add(1, 1'b0, MT_W,  32'h10,   32'h11223344, 32'hDEADBEEF, 0, 1'b0);
        add(1, 1'b0, MT_B,  32'h13,   32'h000000AA, 32'hDEADBEEF, 0, 1'b0);
        add(1, 1'b1, MT_B,  32'h13,   32'h0,        32'h000000AA, 1, 1'b0);
        add(1, 1'b1, MT_W,  32'h10,   32'h0,        32'hAA223344, 1, 1'b0);
        add(1, 1'b1, MT_BU, 32'h12,   32'h0,        32'h00000022, 1, 1'b0);
        add(1, 1'b0, MT_W,  32'h20,   32'h00000000, 32'h00000022, 0, 1'b0);
        add(1, 1'b0, MT_H,  32'h22,   32'h00005566, 32'h00000022, 0, 1'b0);
        add(1, 1'b1, MT_HU, 32'h22,   32'h0,        32'h00005566, 1, 1'b0);
        add(1, 1'b1, MT_H,  32'h20,   32'h0,        32'h00000000, 1, 1'b0);
        add(1, 1'b1, MT_W,  32'h20,   32'h0,        32'h55660000, 1, 1'b0);
        add(1, 1'b0, MT_W,  32'h30,   32'h12345678, 32'h55660000, 0, 1'b0);
        add(1, 1'b1, MT_W,  32'h30,   32'h0,        32'h12345678, 1, 1'b0);
        add(1, 1'b0, MT_W,  32'h31,   32'hFFFFFFFF, 32'h12345678, 0, 1'b1);
        add(1, 1'b1, MT_H,  32'h33,   32'h0,        32'h12345678, 0, 1'b1);
        add(1, 1'b1, MT_B,  32'h11,   32'h0,        32'h00000033, 1, 1'b0);
        add(1, 1'b1, MT_W,  32'h30,   32'h0,        32'h12345678, 1, 1'b0);
        add(1, 1'b1, MT_X,  32'h10,   32'h0,        32'h12345678, 0, 1'b0);
        add(1, 1'b0, MT_HU, 32'h12,   32'h0000BEEF, 32'h12345678, 0, 1'b0);
        add(1, 1'b1, MT_W,  32'h10,   32'h0,        32'hBEEF3344, 1, 1'b0);
        add(1, 1'b1, MT_B,  32'h13,   32'h0,        32'h000000BE, 1, 1'b0);
        add(0, 1'b0, MT_W,  32'h40,   32'h0000CAFE, 32'h00000000, 0, 1'b0);
        add(0, 1'b1, MT_W,  32'h40,   32'h0,        32'h0000CAFE, 0, 1'b0);
        add(0, 1'b1, MT_W,  32'h1040, 32'h0,        32'h0000CAFE, 0, 1'b0);
        add(0, 1'b1, MT_B,  32'h41,   32'h0,        32'h000000CA, 0, 1'b0);
        add(0, 1'b1, MT_H,  32'h42,   32'h0,        32'h00000000, 0, 1'b0);
        add(0, 1'b0, MT_B,  32'h1043, 32'h00000077, 32'h00000000, 0, 1'b0);
        add(0, 1'b1, MT_W,  32'h40,   32'h0,        32'h7700CAFE, 0, 1'b0);
        add(0, 1'b1, MT_HU, 32'h41,   32'h0,        32'h7700CAFE, 0, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn0 = 1'b1; rstn1 = 1'b1; rstn2 = 1'b1;
        @(posedge clk); #1;

        for (int s = 0; s < 3; s++) begin
            check("reset_dout",  s, get_dout(s), 32'h0);
            check("reset_ready", s, {31'b0, get_ready(s)}, 32'h1);
            check("reset_err",   s, {31'b0, get_err(s)}, 32'h0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].sel, vecs[i].wen, vecs[i].be, vecs[i].addr, vecs[i].di, st, er);
            check("dout",  i, get_dout(vecs[i].sel), vecs[i].exp_dout);
            check("stall", i, 32'(st), 32'(vecs[i].exp_stall));
            check("err",   i, {31'b0, er}, {31'b0, vecs[i].exp_err});
        end

        // Misalign flag lasts exactly one cycle
        do_req(1, 1'b0, MT_W, 32'h31, 32'hFFFFFFFF, st, er);
        check("misalign_pulse", 0, {31'b0, er}, 32'h1);
        @(posedge clk); #1;
        check("misalign_clear", 0, {31'b0, get_err(1)}, 32'h0);
        check("misalign_ready", 0, {31'b0, get_ready(1)}, 32'h1);

        // Reset asserted during the first wait cycle of a two-wait-state read
        do_req(2, 1'b0, MT_W, 32'h50, 32'h0BADF00D, st, er);
        do_req(2, 1'b1, MT_W, 32'h50, 32'h0, st, er);
        check("ws2_dout",  0, get_dout(2), 32'h0BADF00D);
        check("ws2_stall", 0, 32'(st), 32'd2);
        do_req(2, 1'b0, MT_W, 32'h54, 32'h600DCAFE, st, er);
        sel = 2; wen = 1'b1; be = MT_W; addr = 32'h54; csn = 1'b0;
        @(posedge clk); #1;
        csn = 1'b1;
        check("midwait_ready", 0, {31'b0, get_ready(2)}, 32'h0);
        rstn2 = 1'b0;
        #1;
        check("rst_dout",  0, get_dout(2), 32'h0);
        check("rst_ready", 0, {31'b0, get_ready(2)}, 32'h1);
        check("rst_err",   0, {31'b0, get_err(2)}, 32'h0);
        @(negedge clk);
        rstn2 = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 0, {31'b0, get_ready(2)}, 32'h1);
        check("post_rst_dout",  0, get_dout(2), 32'h0);
        do_req(2, 1'b1, MT_W, 32'h54, 32'h0, st, er);
        check("reread_dout",  0, get_dout(2), 32'h600DCAFE);
        check("reread_stall", 0, 32'(st), 32'd2);
        do_req(2, 1'b1, MT_HU, 32'h52, 32'h0, st, er);
        check("array_kept", 0, get_dout(2), 32'h00000BAD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
